drbg_stream_ctrl: RTL and testbench

DRBG_STREAM_CTRL -- requirements
Module: drbg_stream_ctrl

---
 rtl/drbg_pkg.sv | 26 ++
 rtl/drbg_block_serializer.sv | 58 +++++
 rtl/drbg_stream_ctrl.sv | 151 +++++++++++++++
 tb/tb_drbg_stream_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drbg_pkg.sv
// drbg_pkg -- shared constants and types for the DRBG output stream controller.
//   BLOCK_W      : width of one generated block (bits).
//   WORD_W       : default output word width.
//   MAX_REQ_BITS : default largest request accepted without error.
//   GEN_TIMEOUT  : default cycle budget between gen_start and gen_done.
//   drbg_state_e : controller state encoding.
package drbg_pkg;

  localparam int BLOCK_W      = 256;
  localparam int WORD_W       = 32;
  localparam int MAX_REQ_BITS = 524288;
  localparam int GEN_TIMEOUT  = 1024;

  // Counter widths: remaining words of a request, words left in / index into a block.
  localparam int REM_W     = 15;
  localparam int WORD_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_GEN,
    ST_STREAM,
    ST_FAULT
  } drbg_state_e;

endpackage

// File: rtl/drbg_block_serializer.sv
// drbg_block_serializer -- holds one generated block and presents it one word at
// a time, most significant word first.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture load_bits and restart at word 0
//   load_bits  : block to capture
//   advance    : step to the next word (a word was consumed)
//   word       : current word
module drbg_block_serializer
  import drbg_pkg::*;
#(
  parameter int WORD_W = drbg_pkg::WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_bits,
  input  logic               advance,
  output logic [WORD_W-1:0]  word
);

  localparam int WORDS_PER_BLK = BLOCK_W / WORD_W;

  logic [BLOCK_W-1:0]    block_q, block_d;
  logic [WORD_IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    block_d = block_q;
    idx_d   = idx_q;
    if (load) begin
      block_d = load_bits;
      idx_d   = '0;
    end else if (advance) begin
      idx_d = idx_q + WORD_IDX_W'(1);
    end
  end

  // Word k sits at the top of the block: block[BLOCK_W-1-WORD_W*k -: WORD_W].
  always_comb begin
    word = '0;
    for (int i = 0; i < WORDS_PER_BLK; i++) begin
      if (idx_q == WORD_IDX_W'(i)) word = block_q[BLOCK_W-1-WORD_W*i -: WORD_W];
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the block register is reset too, so no stale random material survives a reset.
      block_q <= '0;
      idx_q   <= '0;
    end else begin
      block_q <= block_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/drbg_stream_ctrl.sv
// drbg_stream_ctrl -- accepts requests for N random bits, fetches 256-bit blocks
// from a generate stage and streams them out as WORD_W-bit words.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/ready/nbits : request handshake and requested bit count
//   gen_start             : one-cycle start pulse to the generate stage
//   gen_done/error/bits   : generate stage completion, error flag and block
//   out_valid/ready/data  : output word stream, out_last marks the final word
//   busy                  : controller not idle
//   err                   : sticky error, cleared when the next request is accepted
module drbg_stream_ctrl
  import drbg_pkg::*;
#(
  parameter int WORD_W       = drbg_pkg::WORD_W,
  parameter int MAX_REQ_BITS = drbg_pkg::MAX_REQ_BITS,
  parameter int GEN_TIMEOUT  = drbg_pkg::GEN_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [31:0]        req_nbits,
  output logic               req_ready,
  output logic               gen_start,
  input  logic               gen_done,
  input  logic               gen_error,
  input  logic [BLOCK_W-1:0] gen_bits,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic               err
);

  localparam int WORDS_PER_BLK = BLOCK_W / WORD_W;
  localparam int WORD_SH       = $clog2(WORD_W);
  localparam int TMO_W         = $clog2(GEN_TIMEOUT);

  drbg_state_e           state_q, state_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [WORD_IDX_W-1:0] blk_q, blk_d;
  logic [WORD_SH-1:0]    tail_q, tail_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  err_q, err_d;

  logic                  ser_load;
  logic [WORD_W-1:0]     ser_word;
  logic [WORD_W-1:0]     tail_mask;
  logic [TMO_W-1:0]      tmo_inc;

  assign req_ready = (state_q == ST_IDLE);
  assign gen_start = (state_q == ST_ISSUE);
  assign out_valid = (state_q == ST_STREAM);
  assign out_last  = out_valid && (rem_q == REM_W'(1));
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign tmo_inc   = tmo_q + TMO_W'(1);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    blk_d    = blk_q;
    tail_d   = tail_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    ser_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          err_d  = 1'b0;
          rem_d  = REM_W'((33'(req_nbits) + 33'(WORD_W - 1)) >> WORD_SH);
          tail_d = req_nbits[WORD_SH-1:0];
          // A zero-bit request completes on acceptance and stays idle.
          if (req_nbits > 32'(MAX_REQ_BITS)) begin
            err_d   = 1'b1;
            state_d = ST_FAULT;
          end else if (req_nbits != '0) begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_GEN;
      end
      ST_WAIT_GEN: begin
        if (gen_done) begin
          if (gen_error) begin
            err_d   = 1'b1;
            state_d = ST_FAULT;
          end else begin
            ser_load = 1'b1;
            blk_d    = (rem_q >= REM_W'(WORDS_PER_BLK)) ? WORD_IDX_W'(WORDS_PER_BLK)
                                                        : rem_q[WORD_IDX_W-1:0];
            state_d  = ST_STREAM;
          end
        end else if (tmo_inc == TMO_W'(GEN_TIMEOUT - 1)) begin
          // Counting from the gen_start cycle, FAULT lands exactly GEN_TIMEOUT cycles later.
          err_d   = 1'b1;
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          rem_d = rem_q - REM_W'(1);
          blk_d = blk_q - WORD_IDX_W'(1);
          if (rem_q == REM_W'(1))            state_d = ST_IDLE;
          else if (blk_q == WORD_IDX_W'(1))  state_d = ST_ISSUE;
        end
      end
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The final word keeps only its upper tail_q bits when the request is not word-aligned.
  always_comb begin
    tail_mask = '1;
    if (out_last && (tail_q != '0)) tail_mask = ~({WORD_W{1'b1}} >> tail_q);
    out_data = out_valid ? (ser_word & tail_mask) : '0;
  end

  drbg_block_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .load_bits(gen_bits),
    .advance  (out_valid && out_ready),
    .word     (ser_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      blk_q   <= '0;
      tail_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      blk_q   <= blk_d;
      tail_q  <= tail_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_drbg_stream_ctrl.sv
// tb_drbg_stream_ctrl -- scoreboard bench for drbg_stream_ctrl. Expected words are
// derived from the delivered blocks by slicing the requested bit string into
// 32-bit words; a monitor compares every presented word against the queue head.
module tb_drbg_stream_ctrl;

  localparam int WW   = 32;
  localparam int MAXB = 524288;
  localparam int GTO  = 1024;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic [31:0]  req_nbits;
  logic         req_ready;
  logic         gen_start;
  logic         gen_done;
  logic         gen_error;
  logic [255:0] gen_bits;
  logic         out_valid;
  logic         out_ready;
  logic [WW-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         err;

  drbg_stream_ctrl #(.WORD_W(WW), .MAX_REQ_BITS(MAXB), .GEN_TIMEOUT(GTO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_nbits(req_nbits), .req_ready(req_ready),
    .gen_start(gen_start), .gen_done(gen_done), .gen_error(gen_error), .gen_bits(gen_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   model_left = 0;
  int   gs_count = 0;
  int   xfer_count = 0;
  int   cyc = 0;
  bit   gen_auto = 1'b1;
  bit   gen_pat = 1'b0;
  int   out_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the request is a bit string taken from successive blocks, MSB first;
  // cut it into 32-bit words, the last one zero-padded on the right.
  function automatic void push_block(input logic [255:0] b);
    exp_t        e;
    logic [31:0] w;
    for (int j = 0; j < 8; j++) begin
      if (model_left <= 0) break;
      w = b[255-32*j -: 32];
      if (model_left < 32) w = (w >> (32 - model_left)) << (32 - model_left);
      e.data = w;
      e.last = (model_left <= 32);
      sb.push_back(e);
      model_left -= 32;
    end
  endfunction

  // Generate-stage model: answers each gen_start after a random delay.
  initial begin
    logic [255:0] b;
    logic [255:0] pat;
    int d;
    pat = {4{64'h0123456789abcdef}};
    forever begin
      @(negedge clk);
      if (gen_auto && gen_start && !rst) begin
        d = $urandom_range(0, 4);
        if (gen_pat) b = pat;
        else for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom();
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1;
        gen_done = 1'b1;
        gen_bits = b;
        push_block(b);
        tick();
        gen_done = 1'b0;
      end
    end
  end

  // Consumer back-pressure.
  initial begin
    int ph;
    ph = 0;
    forever begin
      tick();
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        2: begin
          out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
          ph++;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every presented word must match the scoreboard head, held until taken.
  initial forever begin
    @(negedge clk);
    if (gen_start) gs_count++;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("word with empty scoreboard", 64'(sb.size()), 64'd1);
      end else begin
        check("out_data", 64'(out_data), 64'(sb[0].data));
        check("out_last", 64'(out_last), 64'(sb[0].last));
        if (out_ready) begin
          void'(sb.pop_front());
          xfer_count++;
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (req_ready && !busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({name, " reaches idle"}, 64'(ok), 64'd1);
  endtask

  task automatic send_req(input int unsigned n);
    req_valid = 1'b1;
    req_nbits = n;
    if (n != 0 && n <= MAXB) model_left = int'(n);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int s0, x0, c0, n;
    bit ok;
    rst = 1'b1; req_valid = 1'b0; req_nbits = '0;
    gen_done = 1'b0; gen_error = 1'b0; gen_bits = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset gen_start", 64'(gen_start), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset err", 64'(err), 64'd0);
    rst = 1'b0;
    tick();

    // Scenario 1: one full block of the fixed pattern.
    wait_idle("s1 pre");
    gen_pat = 1'b1; s0 = gs_count; x0 = xfer_count;
    send_req(256);
    wait_idle("s1");
    check("s1 gen_start count", 64'(gs_count - s0), 64'd1);
    check("s1 transfers", 64'(xfer_count - x0), 64'd8);
    gen_pat = 1'b0;

    // Scenario 2: two blocks, masked tail word.
    s0 = gs_count; x0 = xfer_count;
    send_req(300);
    wait_idle("s2");
    check("s2 gen_start count", 64'(gs_count - s0), 64'd2);
    check("s2 transfers", 64'(xfer_count - x0), 64'd10);

    // Scenario 3: stalls on the output.
    out_mode = 2; s0 = gs_count; x0 = xfer_count;
    send_req(64);
    wait_idle("s3");
    check("s3 transfers", 64'(xfer_count - x0), 64'd2);
    out_mode = 0;

    // gen_done/gen_error while idle have no effect.
    s0 = gs_count;
    gen_done = 1'b1; gen_error = 1'b1;
    tick();
    gen_done = 1'b0; gen_error = 1'b0;
    tick();
    check("stray gen_done err", 64'(err), 64'd0);
    check("stray gen_done idle", 64'(req_ready), 64'd1);
    check("stray gen_done gen_start", 64'(gs_count - s0), 64'd0);

    // Scenario 4: generate error on the first block.
    gen_auto = 1'b0; x0 = xfer_count;
    send_req(100);
    check("s4 gen_start", 64'(gen_start), 64'd1);
    tick();
    gen_done = 1'b1; gen_error = 1'b1;
    for (int i = 0; i < 8; i++) gen_bits[32*i +: 32] = $urandom();
    tick();
    gen_done = 1'b0; gen_error = 1'b0;
    check("s4 fault busy", 64'(busy), 64'd1);
    check("s4 fault err", 64'(err), 64'd1);
    check("s4 fault out_valid", 64'(out_valid), 64'd0);
    check("s4 fault req_ready", 64'(req_ready), 64'd0);
    tick();
    check("s4 back to idle", 64'(req_ready), 64'd1);
    repeat (5) tick();
    check("s4 err sticky", 64'(err), 64'd1);
    gen_auto = 1'b1;
    send_req(32);
    check("s4 err cleared on accept", 64'(err), 64'd0);
    wait_idle("s4");
    check("s4 transfers", 64'(xfer_count - x0), 64'd1);

    // Scenario 5: gen_done never returns.
    gen_auto = 1'b0;
    send_req(64);
    c0 = cyc;
    check("s5 gen_start", 64'(gen_start), 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (err) begin
        ok = 1'b1;
        break;
      end
    end
    check("s5 timeout reached", 64'(ok), 64'd1);
    check("s5 fault latency", 64'(cyc - c0), 64'(GTO));
    check("s5 fault busy", 64'(busy), 64'd1);
    tick();
    check("s5 idle req_ready", 64'(req_ready), 64'd1);
    check("s5 idle busy", 64'(busy), 64'd0);
    gen_auto = 1'b1;

    // Scenario 6a/6b: zero-bit and oversize requests.
    s0 = gs_count;
    send_req(0);
    check("s6 zero req_ready", 64'(req_ready), 64'd1);
    check("s6 zero busy", 64'(busy), 64'd0);
    send_req(MAXB + 1);
    check("s6 oversize err", 64'(err), 64'd1);
    check("s6 oversize busy", 64'(busy), 64'd1);
    tick();
    check("s6 oversize idle", 64'(req_ready), 64'd1);
    check("s6 no gen_start", 64'(gs_count - s0), 64'd0);

    // Random requests with random back-pressure.
    out_mode = 1;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 700);
      wait_idle("rand pre");
      s0 = gs_count; x0 = xfer_count;
      send_req(n);
      wait_idle("rand");
      check("rand gen_start count", 64'(gs_count - s0), 64'((n + 255) / 256));
      check("rand transfers", 64'(xfer_count - x0), 64'((n + 31) / 32));
    end
    out_mode = 0;

    // Scenario 6c: reset while streaming.
    wait_idle("s6 rst pre");
    out_mode = 3;
    tick();
    s0 = gs_count; x0 = xfer_count;
    send_req(256);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("s6 stream reached", 64'(ok), 64'd1);
    rst = 1'b1;
    #1;
    check("s6 rst out_valid", 64'(out_valid), 64'd0);
    check("s6 rst out_last", 64'(out_last), 64'd0);
    check("s6 rst out_data", 64'(out_data), 64'd0);
    check("s6 rst busy", 64'(busy), 64'd0);
    check("s6 rst req_ready", 64'(req_ready), 64'd1);
    sb.delete();
    model_left = 0;
    tick();
    tick();
    rst = 1'b0;
    out_mode = 0;
    repeat (20) tick();
    check("s6 no words after reset", 64'(xfer_count - x0), 64'd0);
    check("s6 no gen_start after reset", 64'(gs_count - s0), 64'd1);
    check("s6 idle after reset", 64'(req_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
